ram_loader_ctrl: RTL

- Sequences programming mode for the 8-bit CPU.
- Loads bytes presented on ui_in into the 16-byte RAM, one handshake per byte.
- Drives the address onto the bus, steers ui_in onto the bus, strobes MAR address/data loads, then strobes the RAM write.
- Holds the CPU control block off the bus (cpu_hold) for the whole session.

---
 rtl/ram_loader_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ram_loader_ctrl.sv
// ram_loader_ctrl
// ---------------------------------------------------------------------------
// Programming-mode sequencer for the 8-bit CPU. While the host holds
// `programming` high, each byte the host presents on ui_in is written into
// RAM through the MAR. The per-byte sequence is: drive the address onto the
// bus and load MAR address, steer ui_in onto the bus and load MAR data, then
// strobe the RAM write. cpu_hold keeps the CPU control block off the bus for
// the whole session.
//
// Handshake: `ready` is high while the controller waits for a byte. The host
// places the byte on ui_in and raises ui_valid; only a 0->1 transition of
// ui_valid seen while ready=1 starts a load. ui_in must stay stable until the
// load completes (ready returns high). A level held high loads exactly once;
// rises while ready=0 are dropped, never queued.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active-high
//   programming    host requests a load session (level)
//   ui_valid       host byte strobe (rising edge counts)
//   ready          waiting for the next byte
//   done_load      all RAM_BYTES written, session complete
//   cpu_hold       CPU control block must keep bus drivers/loads inactive
//   addr_drive_en  drive {0, addr_out} onto the bus
//   addr_out       current load address
//   read_ui_in     steer ui_in onto the bus
//   n_load_addr    MAR address load, active-low
//   n_load_data    MAR data load, active-low
//   n_write_ram    RAM write, active-low
//   bytes_loaded   bytes written this session
//   state_dbg      current FSM state (0 IDLE, 1 WAIT_BYTE, 2 LOAD_ADDR,
//                  3 LOAD_DATA, 4 WRITE, 5 DONE)
// ---------------------------------------------------------------------------
module ram_loader_ctrl #(
  parameter int RAM_BYTES = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              programming,
  input  logic              ui_valid,
  output logic              ready,
  output logic              done_load,
  output logic              cpu_hold,
  output logic              addr_drive_en,
  output logic [ADDR_W-1:0] addr_out,
  output logic              read_ui_in,
  output logic              n_load_addr,
  output logic              n_load_data,
  output logic              n_write_ram,
  output logic [ADDR_W:0]   bytes_loaded,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE = 3'd1,
    S_LOAD_ADDR = 3'd2,
    S_LOAD_DATA = 3'd3,
    S_WRITE     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_t state;
  state_t state_n;
  logic   valid_q;
  logic   rise;

  assign rise      = ui_valid & ~valid_q;
  assign state_dbg = state;

  // Next-state logic. A rise coinciding with programming=0 is ignored: the
  // abort takes priority so no load starts in a session being torn down.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (programming) state_n = S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        if (!programming) state_n = S_IDLE;
        else if (rise)    state_n = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: state_n = S_LOAD_DATA;
      S_LOAD_DATA: state_n = S_WRITE;
      S_WRITE: begin
        if (addr_out == LAST_ADDR) state_n = S_DONE;
        else if (programming)      state_n = S_WAIT_BYTE;
        else                       state_n = S_IDLE;
      end
      S_DONE:      if (!programming) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // State, address/count and outputs. Outputs are registered decodes of the
  // next state, so they line up with `state` and never depend on inputs
  // combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      valid_q       <= 1'b0;
      addr_out      <= '0;
      bytes_loaded  <= '0;
      ready         <= 1'b0;
      done_load     <= 1'b0;
      cpu_hold      <= 1'b0;
      addr_drive_en <= 1'b0;
      read_ui_in    <= 1'b0;
      n_load_addr   <= 1'b1;
      n_load_data   <= 1'b1;
      n_write_ram   <= 1'b1;
    end else begin
      valid_q <= ui_valid;
      state   <= state_n;

      case (state)
        S_IDLE: begin
          if (programming) begin
            addr_out     <= '0;
            bytes_loaded <= '0;
          end
        end
        S_WRITE: begin
          bytes_loaded <= bytes_loaded + CNT_ONE;
          // No wrap: the last address is kept while sitting in DONE.
          if (addr_out != LAST_ADDR) addr_out <= addr_out + ADDR_ONE;
        end
        default: ;
      endcase

      ready         <= (state_n == S_WAIT_BYTE);
      done_load     <= (state_n == S_DONE);
      cpu_hold      <= (state_n != S_IDLE);
      addr_drive_en <= (state_n == S_LOAD_ADDR);
      read_ui_in    <= (state_n == S_LOAD_DATA);
      n_load_addr   <= (state_n != S_LOAD_ADDR);
      n_load_data   <= (state_n != S_LOAD_DATA);
      n_write_ram   <= (state_n != S_WRITE);
    end
  end

endmodule
